vu_level_detector: RTL
======================

VU_LEVEL_DETECTOR -- requirements
Module: vu_level_detector

Interface
REQ-001 SHALL have parameter DECIM, default 16: audio_enable strobes per level window; power of two, 2..256.
REQ-002 SHALL have parameter DECAY_SHIFT, default 4: release shift, env -= env>>DECAY_SHIFT per window.
REQ-003 SHALL have parameter CLIP_HOLD, default 8: windows a clip flag stays high after the last clipped window.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port audio_enable  input  1  one-cycle strobe per stereo sample (96 kHz); strobes are at least 3 clk apart.
REQ-007 SHALL have ports l_audio_signal, r_audio_signal  input  16  two's-complement samples, valid when audio_enable=1.
REQ-008 SHALL have ports l_level, r_level  output  16  unsigned envelope magnitude, 0..32767, feeding the VU meter driver.
REQ-009 SHALL have port level_valid  output  1  one-cycle pulse when l_level/r_level update.
REQ-010 SHALL have ports clip_l, clip_r  output  1  clip indicator per channel.

Function
REQ-011 SHALL register |sample| per channel in the cycle after audio_enable; -32768 SHALL saturate to 32767.
REQ-012 SHALL hold a per-channel window peak = max |sample| over the current window; the peak SHALL clear to 0 when the window closes.
REQ-013 SHALL count strobes with a log2(DECIM)-bit window counter; the DECIM-th strobe closes the window and the counter SHALL wrap to 0.
REQ-014 At window close, if peak >= env: env SHALL load peak (instant attack).
REQ-015 At window close, if peak < env: env SHALL load env - (env>>DECAY_SHIFT); if env>>DECAY_SHIFT = 0 and env > 0, env SHALL decrement by 1; env = 0 SHALL stay 0.
REQ-016 The closing sample SHALL be included in that window's peak.
REQ-017 level_valid SHALL be high exactly 2 clk after the edge that samples the closing audio_enable; l_level/r_level SHALL show the new env in that same cycle and hold until the next update.
REQ-018 A window SHALL be marked clipped for a channel if any raw sample in it is 32767 or -32768.
REQ-019 Pipeline SHALL be two stages: S1 abs/clip detect, S2 peak merge + envelope/clip update; no backpressure.
REQ-020 audio_enable low SHALL freeze all state except the level_valid pulse clearing.

Reset
REQ-021 reset low SHALL clear, asynchronously: counter, peaks, env, pipeline regs, clip hold counters; outputs l_level=0, r_level=0, level_valid=0, clip_l=0, clip_r=0.
REQ-022 Release of reset SHALL be synchronised to clk; the first strobe after release SHALL start a fresh window.
REQ-023 Reset mid-window SHALL discard the partial window; no level_valid SHALL be emitted for it.

Configuration
REQ-024 Macro VU_LEVEL_CLIP_HOLD_EN defined: a clipped window SHALL set clip_x=1 and load hold=CLIP_HOLD in the same cycle as level_valid; each non-clipped window close SHALL decrement hold; clip_x SHALL drop when hold reaches 0; a new clip SHALL reload hold.
REQ-025 Macro VU_LEVEL_CLIP_HOLD_EN undefined: no clip logic or hold counters SHALL be built; clip_l and clip_r SHALL be constant 0.

Verification (DECIM=16, DECAY_SHIFT=4, CLIP_HOLD=8)
REQ-026 Reset asserted with random inputs -> all outputs 0 and no level_valid for the whole reset period.
REQ-027 16 strobes of l=+1000, r=-2000 -> one level_valid 2 clk after the 16th strobe; l_level=1000, r_level=2000.
REQ-028 16 further strobes of zeros -> l_level=938, r_level=1875; with env=10 and zero input -> env goes 10→9→8.
REQ-029 One strobe of l=-32768 in a window, zeros after -> l_level=32767; with the macro, clip_l high for that window plus 8 closes, then 0; without the macro, clip_l=0 throughout.
REQ-030 Reset pulsed after 7 strobes, then 16 strobes of 500 -> no level_valid for the partial window; one level_valid after the 16th post-reset strobe, level=500.
REQ-031 Strobes 512 clk apart, 64 windows -> exactly 64 level_valid pulses, each one clk wide.

Source files
------------

// File: rtl/vu_level_detector.sv
// ---------------------------------------------------------------------------
// vu_level_detector
//   Stereo peak/envelope detector for a VU meter. Each channel's |sample| is
//   taken over a window of DECIM audio strobes. At the end of each window the
//   envelope jumps straight up to the window peak, or else decays by
//   env >> DECAY_SHIFT.
//
// Optional build macro:
//   VU_LEVEL_CLIP_HOLD_EN - builds per-channel clip detection with a hold
//                           counter. When it is undefined, clip_l and clip_r
//                           are tied to 0.
//
// Ports:
//   clk            - system clock; all logic runs on the rising edge
//   reset          - asynchronous active-low reset (release is synchronised)
//   audio_enable   - one-cycle strobe per stereo sample
//   l/r_audio_signal - two's-complement samples, valid with audio_enable
//   l_level/r_level  - envelope magnitude 0..32767, held between updates
//   level_valid    - one-cycle pulse when l_level/r_level update
//   clip_l/clip_r  - clip indicators, updated together with level_valid
//
// Latency: the strobe that closes a window is sampled at edge E0.
//   E0: S1 registers the abs value and the clip flag.
//   E1: S2 merges the peak and updates the envelope.
//   E2: the output registers load, and level_valid is high.
// ---------------------------------------------------------------------------
module vu_level_detector #(
  parameter int DECIM       = 16,
  parameter int DECAY_SHIFT = 4,
  parameter int CLIP_HOLD   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        audio_enable,
  input  logic [15:0] l_audio_signal,
  input  logic [15:0] r_audio_signal,
  output logic [15:0] l_level,
  output logic [15:0] r_level,
  output logic        level_valid,
  output logic        clip_l,
  output logic        clip_r
);

  localparam int            CW       = $clog2(DECIM);
  localparam logic [CW-1:0] LAST_IDX = CW'(DECIM - 1);

  // |s|, with -32768 saturating to 32767
  function automatic logic [15:0] sat_abs(input logic [15:0] s);
    logic [15:0] a;
    if (s == 16'h8000) begin
      a = 16'h7fff;
    end else if (s[15]) begin
      a = 16'(~s + 16'd1);
    end else begin
      a = s;
    end
    return a;
  endfunction

  // Instant attack; the release step is at least 1 while env is non-zero
  function automatic logic [15:0] env_next(input logic [15:0] env, input logic [15:0] peak);
    logic [15:0] d;
    logic [15:0] n;
    d = env >> DECAY_SHIFT;
    if (peak >= env) begin
      n = peak;
    end else if (d != 16'd0) begin
      n = env - d;
    end else if (env != 16'd0) begin
      n = env - 16'd1;
    end else begin
      n = 16'd0;
    end
    return n;
  endfunction

  logic          rst_meta_r, rst_sync_r;
  logic [CW-1:0] cnt_r;
  logic          s1_valid_r, s1_close_r;
  logic [15:0]   abs_l_r, abs_r_r;
  logic [15:0]   peak_l_r, peak_r_r;
  logic [15:0]   peak_l_m_s, peak_r_m_s;
  logic [15:0]   env_l_r, env_r_r;
  logic          close_s2_r;

  // Reset synchroniser: assertion is immediate, release takes two clk edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  // S1: abs value capture, window counter and window-close tag
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      cnt_r      <= {CW{1'b0}};
      s1_valid_r <= 1'b0;
      s1_close_r <= 1'b0;
      abs_l_r    <= 16'd0;
      abs_r_r    <= 16'd0;
    end else if (audio_enable) begin
      cnt_r      <= cnt_r + CW'(1);
      s1_valid_r <= 1'b1;
      s1_close_r <= (cnt_r == LAST_IDX);
      abs_l_r    <= sat_abs(l_audio_signal);
      abs_r_r    <= sat_abs(r_audio_signal);
    end else begin
      s1_valid_r <= 1'b0;
    end
  end

  // Merge the S1 sample into the running peak; the closing sample is included
  always_comb begin
    peak_l_m_s = (abs_l_r > peak_l_r) ? abs_l_r : peak_l_r;
    peak_r_m_s = (abs_r_r > peak_r_r) ? abs_r_r : peak_r_r;
  end

  // S2: peak accumulation and envelope update at window close
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      peak_l_r   <= 16'd0;
      peak_r_r   <= 16'd0;
      env_l_r    <= 16'd0;
      env_r_r    <= 16'd0;
      close_s2_r <= 1'b0;
    end else if (s1_valid_r && s1_close_r) begin
      peak_l_r   <= 16'd0;
      peak_r_r   <= 16'd0;
      env_l_r    <= env_next(env_l_r, peak_l_m_s);
      env_r_r    <= env_next(env_r_r, peak_r_m_s);
      close_s2_r <= 1'b1;
    end else if (s1_valid_r) begin
      peak_l_r   <= peak_l_m_s;
      peak_r_r   <= peak_r_m_s;
      close_s2_r <= 1'b0;
    end else begin
      close_s2_r <= 1'b0;
    end
  end

  // Output stage: the levels load and hold, and level_valid pulses for one cycle
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      l_level     <= 16'd0;
      r_level     <= 16'd0;
      level_valid <= 1'b0;
    end else if (close_s2_r) begin
      l_level     <= env_l_r;
      r_level     <= env_r_r;
      level_valid <= 1'b1;
    end else begin
      level_valid <= 1'b0;
    end
  end

`ifdef VU_LEVEL_CLIP_HOLD_EN
  localparam int            HW        = $clog2(CLIP_HOLD + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(CLIP_HOLD);

  function automatic logic is_clip(input logic [15:0] s);
    return (s == 16'h7fff) || (s == 16'h8000);
  endfunction

  logic          s1_clip_l_r, s1_clip_r_r;
  logic          win_clip_l_r, win_clip_r_r;
  logic [HW-1:0] hold_l_r, hold_r_r;
  logic          clip_s2_l_r, clip_s2_r_r;

  // S1: raw full-scale detection (before saturation hides -32768)
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      s1_clip_l_r <= 1'b0;
      s1_clip_r_r <= 1'b0;
    end else if (audio_enable) begin
      s1_clip_l_r <= is_clip(l_audio_signal);
      s1_clip_r_r <= is_clip(r_audio_signal);
    end else begin
      s1_clip_l_r <= s1_clip_l_r;
      s1_clip_r_r <= s1_clip_r_r;
    end
  end

  // S2: clip hold. A clipped window loads the hold counter. Each later clean
  // close still shows clip while hold is non-zero and then counts hold down.
  // So clip stays high for the clipped window plus CLIP_HOLD more closes.
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      win_clip_l_r <= 1'b0;
      win_clip_r_r <= 1'b0;
      hold_l_r     <= {HW{1'b0}};
      hold_r_r     <= {HW{1'b0}};
      clip_s2_l_r  <= 1'b0;
      clip_s2_r_r  <= 1'b0;
    end else if (s1_valid_r && s1_close_r) begin
      win_clip_l_r <= 1'b0;
      win_clip_r_r <= 1'b0;
      if (win_clip_l_r || s1_clip_l_r) begin
        hold_l_r    <= HOLD_INIT;
        clip_s2_l_r <= 1'b1;
      end else begin
        hold_l_r    <= (hold_l_r != {HW{1'b0}}) ? hold_l_r - HW'(1) : hold_l_r;
        clip_s2_l_r <= (hold_l_r != {HW{1'b0}});
      end
      if (win_clip_r_r || s1_clip_r_r) begin
        hold_r_r    <= HOLD_INIT;
        clip_s2_r_r <= 1'b1;
      end else begin
        hold_r_r    <= (hold_r_r != {HW{1'b0}}) ? hold_r_r - HW'(1) : hold_r_r;
        clip_s2_r_r <= (hold_r_r != {HW{1'b0}});
      end
    end else if (s1_valid_r) begin
      win_clip_l_r <= win_clip_l_r | s1_clip_l_r;
      win_clip_r_r <= win_clip_r_r | s1_clip_r_r;
    end else begin
      win_clip_l_r <= win_clip_l_r;
      win_clip_r_r <= win_clip_r_r;
    end
  end

  // Clip outputs update in the same cycle as level_valid
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      clip_l <= 1'b0;
      clip_r <= 1'b0;
    end else if (close_s2_r) begin
      clip_l <= clip_s2_l_r;
      clip_r <= clip_s2_r_r;
    end else begin
      clip_l <= clip_l;
      clip_r <= clip_r;
    end
  end
`else
  assign clip_l = 1'b0;
  assign clip_r = 1'b0;
`endif

endmodule
